// File: rtl/controle_pkg.sv
// Shared opcode, ALU one-hot and FSM state definitions for the multi-cycle
// control unit.
package controle_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_MCLR = 3'b100;
    localparam logic [2:0] OP_ILL  = 3'b101;
    localparam logic [2:0] OP_MRD  = 3'b110;
    localparam logic [2:0] OP_MWR  = 3'b111;

    localparam logic [3:0] ULA_NONE = 4'b0000;
    localparam logic [3:0] ULA_ADD  = 4'b1000;
    localparam logic [3:0] ULA_SUB  = 4'b0100;
    localparam logic [3:0] ULA_MUL  = 4'b0010;
    localparam logic [3:0] ULA_DIV  = 4'b0001;

    typedef enum logic [2:0] {
        IDLE,
        ULA_START,
        ULA_WAIT,
        MEM_REQ,
        WRITEBACK
    } state_t;

    typedef enum logic [1:0] {
        CLS_ULA,
        CLS_MEM,
        CLS_ILL
    } op_class_t;

    function automatic op_class_t op_class(input logic [2:0] op);
        op_class_t cls;
        if (!op[2])
            cls = CLS_ULA;
        else if (op == OP_ILL)
            cls = CLS_ILL;
        else
            cls = CLS_MEM;
        return cls;
    endfunction

    function automatic logic [3:0] ula_onehot(input logic [2:0] op);
        logic [3:0] onehot;
        case (op)
            OP_ADD:  onehot = ULA_ADD;
            OP_SUB:  onehot = ULA_SUB;
            OP_DIV:  onehot = ULA_DIV;
            OP_MUL:  onehot = ULA_MUL;
            default: onehot = ULA_NONE;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/controle_multiciclo_if.sv
// Bundle of instruction, ALU, memory and register-bank handshake signals
// seen by the multi-cycle control unit.
interface controle_multiciclo_if #(
    parameter int INSTR_W   = 32,
    parameter int OP_W      = 3,
    parameter int REG_SEL_W = 2
);
    localparam int IMM_W = INSTR_W - OP_W - 2 * REG_SEL_W;

    logic                 _instr_valid;
    logic                 _instr_ready;
    logic [INSTR_W-1:0]   _instrucao;
    logic [3:0]           _ula_op;
    logic                 _ula_start;
    logic                 _ula_done;
    logic [1:0]           _mem_control;
    logic                 _mem_enable;
    logic                 _mem_ack;
    logic [REG_SEL_W-1:0] _reg_dest;
    logic                 _reg_write;
    logic [IMM_W-1:0]     _imediato;
    logic                 _ilegal;
    logic                 _timeout;

    modport slave (
        input  _instr_valid, _instrucao, _ula_done, _mem_ack,
        output _instr_ready, _ula_op, _ula_start, _mem_control, _mem_enable,
               _reg_dest, _reg_write, _imediato, _ilegal, _timeout
    );

    modport master (
        output _instr_valid, _instrucao, _ula_done, _mem_ack,
        input  _instr_ready, _ula_op, _ula_start, _mem_control, _mem_enable,
               _reg_dest, _reg_write, _imediato, _ilegal, _timeout
    );

endinterface

// File: rtl/controle_timeout.sv
// Watchdog counter: counts cycles spent waiting without a hit and flags the
// last allowed cycle. TIMEOUT=0 disables expiry entirely.
module controle_timeout #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    input  logic hit,
    output logic expired
);
    localparam bit ENABLED = (TIMEOUT > 0);
    localparam int CNT_W   = ENABLED ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = ENABLED ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] count_reg;

    // Saturates at LAST so a disabled or abandoned wait never wraps.
    always_ff @(posedge clk) begin
        if (!reset_n || clear)
            count_reg <= '0;
        else if (enable && !hit && count_reg != LAST)
            count_reg <= count_reg + 1'b1;
    end

    assign expired = ENABLED && enable && !hit && (count_reg == LAST);

endmodule

// File: rtl/controle_multiciclo.sv
// Multi-cycle control unit: latches one instruction, sequences the ALU and
// memory handshakes, pulses write-back and reports illegal opcodes/timeouts.
module controle_multiciclo
    import controle_pkg::*;
#(
    parameter int INSTR_W   = 32,
    parameter int OP_W      = 3,
    parameter int REG_SEL_W = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic                  _clock,
    input  logic                  _reset_n,
    controle_multiciclo_if.slave  bus
);
    localparam int IMM_W = INSTR_W - OP_W - 2 * REG_SEL_W;
    localparam int FA_HI = INSTR_W - OP_W - 1;
    localparam int FB_HI = FA_HI - REG_SEL_W;

    state_t             state_reg;
    logic [INSTR_W-1:0] ir_reg;
    logic               ir_loaded_reg;
    logic               ready_reg;
    logic               ula_start_reg;
    logic               mem_enable_reg;
    logic               reg_write_reg;
    logic               ilegal_reg;
    logic               timeout_reg;

    logic [2:0]         in_op;
    logic [2:0]         ir_op;
    logic               accept;
    logic               wd_clear;
    logic               wd_enable;
    logic               wd_hit;
    logic               wd_expired;

    assign in_op  = 3'(bus._instrucao[INSTR_W-1 -: OP_W]);
    assign ir_op  = 3'(ir_reg[INSTR_W-1 -: OP_W]);
    assign accept = bus._instr_valid && ready_reg;

    // Held clear outside the wait states, so every wait starts from zero.
    assign wd_enable = (state_reg == ULA_WAIT) || (state_reg == MEM_REQ);
    assign wd_clear  = !wd_enable;
    assign wd_hit    = (state_reg == ULA_WAIT) ? bus._ula_done : bus._mem_ack;

    controle_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (_clock),
        .reset_n (_reset_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .hit     (wd_hit),
        .expired (wd_expired)
    );

    always_ff @(posedge _clock) begin
        if (!_reset_n) begin
            state_reg      <= IDLE;
            ir_reg         <= '0;
            ir_loaded_reg  <= 1'b0;
            ready_reg      <= 1'b0;
            ula_start_reg  <= 1'b0;
            mem_enable_reg <= 1'b0;
            reg_write_reg  <= 1'b0;
            ilegal_reg     <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            ula_start_reg <= 1'b0;
            reg_write_reg <= 1'b0;
            ilegal_reg    <= 1'b0;
            timeout_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b1;
                    if (accept) begin
                        ir_reg        <= bus._instrucao;
                        ir_loaded_reg <= 1'b1;
                        case (op_class(in_op))
                            CLS_ULA: begin
                                state_reg     <= ULA_START;
                                ula_start_reg <= 1'b1;
                                ready_reg     <= 1'b0;
                            end
                            CLS_MEM: begin
                                state_reg      <= MEM_REQ;
                                mem_enable_reg <= 1'b1;
                                ready_reg      <= 1'b0;
                            end
                            default: ilegal_reg <= 1'b1;
                        endcase
                    end
                end
                ULA_START: state_reg <= ULA_WAIT;
                ULA_WAIT: begin
                    // Done takes priority over a simultaneous expiry.
                    if (bus._ula_done) begin
                        state_reg     <= WRITEBACK;
                        reg_write_reg <= 1'b1;
                    end else if (wd_expired) begin
                        state_reg   <= IDLE;
                        timeout_reg <= 1'b1;
                        ready_reg   <= 1'b1;
                    end
                end
                MEM_REQ: begin
                    if (bus._mem_ack) begin
                        mem_enable_reg <= 1'b0;
                        if (ir_op == OP_MRD) begin
                            state_reg     <= WRITEBACK;
                            reg_write_reg <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                            ready_reg <= 1'b1;
                        end
                    end else if (wd_expired) begin
                        mem_enable_reg <= 1'b0;
                        state_reg      <= IDLE;
                        timeout_reg    <= 1'b1;
                        ready_reg      <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg      <= IDLE;
                    ready_reg      <= 1'b1;
                    mem_enable_reg <= 1'b0;
                end
            endcase
        end
    end

    // Decode purely from IR; everything reads as zero until the first accept.
    always_comb begin
        bus._ula_op      = ULA_NONE;
        bus._mem_control = 2'b00;
        bus._reg_dest    = '0;
        bus._imediato    = '0;
        if (ir_loaded_reg) begin
            bus._imediato = ir_reg[IMM_W-1:0];
            if (op_class(ir_op) == CLS_ULA) begin
                bus._ula_op   = ula_onehot(ir_op);
                bus._reg_dest = ir_reg[FA_HI -: REG_SEL_W];
            end else begin
                bus._mem_control = ir_op[1:0];
                bus._reg_dest    = ir_reg[FB_HI -: REG_SEL_W];
            end
        end
    end

    assign bus._instr_ready = ready_reg;
    assign bus._ula_start   = ula_start_reg;
    assign bus._mem_enable  = mem_enable_reg;
    assign bus._reg_write   = reg_write_reg;
    assign bus._ilegal      = ilegal_reg;
    assign bus._timeout     = timeout_reg;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Randomised bench for controle_multiciclo: each transaction's expected
// waveform is derived from cycle offsets relative to the accept edge.
module tb_controle_multiciclo;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    controle_multiciclo_if #(.INSTR_W(32), .OP_W(3), .REG_SEL_W(2)) bus ();

    controle_multiciclo #(
        .INSTR_W   (32),
        .OP_W      (3),
        .REG_SEL_W (2),
        .TIMEOUT   (TO)
    ) dut (
        ._clock   (clk),
        ._reset_n (reset_n),
        .bus      (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] ctl_now();
        return {bus._instr_ready, bus._ula_start, bus._mem_enable,
                bus._reg_write, bus._ilegal, bus._timeout};
    endfunction

    function automatic logic [3:0] exp_ula_op(input logic [2:0] op);
        logic [3:0] r;
        case (op)
            3'd0:    r = 4'b1000;
            3'd1:    r = 4'b0100;
            3'd2:    r = 4'b0001;
            3'd3:    r = 4'b0010;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    // Called at a negedge where the unit is ready; returns at the negedge of
    // the cycle in which it is ready again. delay >= TO means no done/ack.
    task automatic run_txn(input logic [31:0] instr, input int delay, input bit junk);
        logic [2:0] op;
        bit   is_ula, is_ill, is_rd, hits;
        int   hit_c, wb_c, to_c, last;
        logic [5:0] exp_ctl;
        op     = instr[31:29];
        is_ula = (op[2] == 1'b0);
        is_ill = (op == 3'b101);
        is_rd  = (op == 3'b110);
        hits   = (delay < TO);
        hit_c  = -1; wb_c = -1; to_c = -1;
        if (is_ill) begin
            last = 1;
        end else if (is_ula) begin
            hit_c = 2 + delay;
            if (hits) begin wb_c = 3 + delay; last = 4 + delay; end
            else begin to_c = 2 + TO; last = to_c; end
        end else begin
            hit_c = 1 + delay;
            if (hits) begin
                if (is_rd) begin wb_c = 2 + delay; last = 3 + delay; end
                else last = 2 + delay;
            end else begin
                to_c = 1 + TO; last = to_c;
            end
        end

        bus._instr_valid = 1'b1;
        bus._instrucao   = instr;
        @(posedge clk);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            bus._instr_valid = junk && (k < last);
            bus._instrucao   = $urandom;
            bus._ula_done    = is_ula && ((hits && k == hit_c) || (junk && k == 1));
            bus._mem_ack     = !is_ula && !is_ill && hits && (k == hit_c);
            exp_ctl = {k == last,
                       is_ula && k == 1,
                       !is_ula && !is_ill && k <= (hits ? hit_c : TO),
                       k == wb_c,
                       is_ill && k == 1,
                       k == to_c};
            check("ctl", 32'(ctl_now()), 32'(exp_ctl));
            if (k == 1 || k == last) begin
                check("ula_op", 32'(bus._ula_op), 32'(exp_ula_op(op)));
                check("imediato", 32'(bus._imediato), 32'(instr[24:0]));
                if (!is_ill)
                    check("mem_control", 32'(bus._mem_control),
                          32'(is_ula ? 2'b00 : op[1:0]));
            end
            if (k == wb_c)
                check("reg_dest", 32'(bus._reg_dest),
                      32'(is_ula ? instr[28:27] : instr[26:25]));
        end
        bus._ula_done = 1'b0;
        bus._mem_ack  = 1'b0;
        $display("txn instr=%08h op=%0d delay=%0d cycles=%0d", instr, op, delay, last);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ctl"}, 32'(ctl_now()), 32'd0);
        check({tag, "_ula_op"}, 32'(bus._ula_op), 32'd0);
        check({tag, "_mem_control"}, 32'(bus._mem_control), 32'd0);
        check({tag, "_reg_dest"}, 32'(bus._reg_dest), 32'd0);
        check({tag, "_imediato"}, 32'(bus._imediato), 32'd0);
    endtask

    initial begin
        logic [31:0] instr;
        bus._instr_valid = 1'b0;
        bus._instrucao   = '0;
        bus._ula_done    = 1'b0;
        bus._mem_ack     = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(ctl_now()), 32'b100000);

        run_txn(32'h0A000005, 0, 1'b0);
        run_txn(32'hC2000000, 3, 1'b0);
        run_txn(32'h40000000, 100, 1'b0);
        run_txn(32'hA0000000, 0, 1'b0);
        run_txn(32'hE0000123, 0, 1'b0);
        run_txn(32'h6C001234, TO - 1, 1'b1);
        run_txn(32'h9E0000FF, TO - 1, 1'b0);
        run_txn(32'hF1000001, TO, 1'b0);

        // Reset in the middle of an ALU wait, with done held high during reset.
        bus._instr_valid = 1'b1;
        bus._instrucao   = 32'h2F00ABCD;
        @(posedge clk);
        bus._instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        bus._ula_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_state("mid_reset");
        end
        reset_n = 1'b1;
        bus._ula_done = 1'b0;
        @(negedge clk);
        check("release_ctl", 32'(ctl_now()), 32'b100000);
        check("release_ula_op", 32'(bus._ula_op), 32'd0);
        $display("txn reset mid-wait");

        for (int n = 0; n < 80; n++) begin
            instr = $urandom;
            run_txn(instr, int'($urandom_range(0, TO + 2)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
